// File: rtl/multi_debounce.sv
// Multi-channel button debouncer: two-flop sync, stable-count filter, press/release/long-press pulses.
// Optional long-press logic is enabled by defining MULTI_DEBOUNCE_LONGPRESS_EN.
module multi_debounce #(
    parameter int CHANNELS   = 4,
    parameter int DB_COUNT   = 120000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_COUNT = 12000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    localparam int              DB_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_COUNT - 1);

`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
    localparam int                LONG_W   = $clog2(LONG_COUNT + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_COUNT);
    localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_COUNT - 1);
`endif

    // The synchronizer holds reset zeros for two edges after reset; with
    // ACTIVE_LOW those zeros read as "pressed", so counting waits until it is primed.
    logic [1:0] r_warm;
    logic       w_sync_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm <= 2'b00;
        end else begin
            r_warm <= {r_warm[0], 1'b1};
        end
    end

    assign w_sync_ok = r_warm[1];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic            r_s1;
        logic            r_s2;
        logic            r_db;
        logic            r_press;
        logic            r_release;
        logic [DB_W-1:0] r_cnt;
        logic            w_lvl;

        assign w_lvl = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; the pulse defaults below are then overridden.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_db      <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_s1      <= btn_in[g];
                r_s2      <= r_s1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (!w_sync_ok || (w_lvl == r_db)) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_MAX) begin
                    r_db      <= w_lvl;
                    r_cnt     <= '0;
                    r_press   <= w_lvl;
                    r_release <= ~w_lvl;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign db_out[g]        = r_db;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;

`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
        logic [LONG_W-1:0] r_long_cnt;
        logic              r_long;

        // Counter saturates, so the pulse fires once per press however long it is held.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_long_cnt <= '0;
                r_long     <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (!r_db) begin
                    r_long_cnt <= '0;
                end else if (r_long_cnt != LONG_MAX) begin
                    r_long_cnt <= r_long_cnt + 1'b1;
                    r_long     <= (r_long_cnt == LONG_PRE);
                end
            end
        end

        assign long_pulse[g] = r_long;
`else
        assign long_pulse[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce (CHANNELS=4, DB_COUNT=4, LONG_COUNT=10) with an ACTIVE_LOW=0
// instance for most steps and an ACTIVE_LOW=1 instance for the inverted-polarity steps.
module tb_multi_debounce;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] db, pp, rp, lp;
    logic       reset_al;
    logic [3:0] btn_al;
    logic [3:0] db_al, pp_al, rp_al, lp_al;

    int n_tests = 0;
    int n_fail  = 0;

    multi_debounce #(
        .CHANNELS(4), .DB_COUNT(4), .ACTIVE_LOW(0), .LONG_COUNT(10)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn),
        .db_out(db), .press_pulse(pp), .release_pulse(rp), .long_pulse(lp)
    );

    multi_debounce #(
        .CHANNELS(4), .DB_COUNT(4), .ACTIVE_LOW(1), .LONG_COUNT(10)
    ) dut_al (
        .clk(clk), .reset(reset_al), .btn_in(btn_al),
        .db_out(db_al), .press_pulse(pp_al), .release_pulse(rp_al), .long_pulse(lp_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        btn      = 4'b0000;
        reset_al = 1'b1;
        btn_al   = 4'b1111;
        tick();
        tick();
        check("rst_db", db, 4'b0000);
        check("rst_press", pp, 4'b0000);
        check("rst_release", rp, 4'b0000);
        check("rst_long", lp, 4'b0000);
        check("al_rst_db", db_al, 4'b0000);
        check("al_rst_press", pp_al, 4'b0000);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_db", db, 4'b0000);

        // Clean press on channel 0: sampled at edge 0, accepted at edge 5.
        btn = 4'b0001;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("p0_wait_db", db, 4'b0000);
            check("p0_wait_press", pp, 4'b0000);
        end
        tick();
        check("p0_e5_db", db, 4'b0001);
        check("p0_e5_press", pp, 4'b0001);
        check("p0_e5_release", rp, 4'b0000);
        tick();
        check("p0_e6_press", pp, 4'b0000);
        check("p0_e6_db", db, 4'b0001);

        // Clean release on channel 0.
        btn = 4'b0000;
        tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("r0_wait_db", db, 4'b0001);
            check("r0_wait_release", rp, 4'b0000);
        end
        tick();
        check("r0_e5_db", db, 4'b0000);
        check("r0_e5_release", rp, 4'b0001);
        tick();
        check("r0_e6_release", rp, 4'b0000);

        // Three-cycle glitch on channel 1 is rejected.
        btn = 4'b0010;
        for (int e = 0; e <= 11; e++) begin
            tick();
            if (e == 2) btn = 4'b0000;
            check("g1_db", db, 4'b0000);
            check("g1_press", pp, 4'b0000);
            check("g1_release", rp, 4'b0000);
        end

        // Four-cycle pulse on channel 1 is exactly long enough to be accepted.
        btn = 4'b0010;
        for (int e = 0; e <= 9; e++) begin
            tick();
            if (e == 3) btn = 4'b0000;
            check("b1_press", pp, (e == 5) ? 4'b0010 : 4'b0000);
            check("b1_release", rp, (e == 9) ? 4'b0010 : 4'b0000);
            check("b1_db", db, (e >= 5 && e < 9) ? 4'b0010 : 4'b0000);
        end
        repeat (2) tick();

        // Long hold on channel 2: long pulse 10 edges after the press pulse when enabled.
        btn = 4'b0100;
        for (int e = 0; e <= 20; e++) begin
            tick();
            check("l2_press", pp, (e == 5) ? 4'b0100 : 4'b0000);
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
            check("l2_long", lp, (e == 15) ? 4'b0100 : 4'b0000);
`else
            check("l2_long", lp, 4'b0000);
`endif
        end
        btn = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("l2_rel", rp, (e == 5) ? 4'b0100 : 4'b0000);
            check("l2_rel_long", lp, 4'b0000);
        end

        // All channels together, then channels 1 and 3 released together.
        btn = 4'b1111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("all_press", pp, (e == 5) ? 4'b1111 : 4'b0000);
            check("all_db", db, (e >= 5) ? 4'b1111 : 4'b0000);
        end
        btn = 4'b0101;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("odd_release", rp, (e == 5) ? 4'b1010 : 4'b0000);
            check("odd_press", pp, 4'b0000);
            check("odd_db", db, (e >= 5) ? 4'b0101 : 4'b1111);
        end
        btn = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("even_release", rp, (e == 5) ? 4'b0101 : 4'b0000);
            check("even_db", db, (e >= 5) ? 4'b0000 : 4'b0101);
        end

        // Reset at edge 3 of a press aborts it; acceptance restarts and lands at edge 9.
        btn = 4'b0001;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_db", db, 4'b0000);
        check("mid_rst_press", pp, 4'b0000);
        reset = 1'b0;
        for (int e = 4; e <= 9; e++) begin
            tick();
            check("mid_rst_restart_press", pp, (e == 9) ? 4'b0001 : 4'b0000);
            check("mid_rst_restart_db", db, (e == 9) ? 4'b0001 : 4'b0000);
        end

        // Reset while pressed clears the level with no release pulse, then re-presses.
        reset = 1'b1;
        tick();
        check("held_rst_db", db, 4'b0000);
        check("held_rst_release", rp, 4'b0000);
        check("held_rst_press", pp, 4'b0000);
        reset = 1'b0;
        for (int e = 11; e <= 16; e++) begin
            tick();
            check("held_rst_repress", pp, (e == 16) ? 4'b0001 : 4'b0000);
            check("held_rst_no_release", rp, 4'b0000);
        end
        btn = 4'b0000;
        repeat (7) tick();
        check("final_db", db, 4'b0000);

        // Active-low instance: idle-high pins through reset give no press.
        reset_al = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check("al_idle_db", db_al, 4'b0000);
            check("al_idle_press", pp_al, 4'b0000);
            check("al_idle_release", rp_al, 4'b0000);
        end
        btn_al = 4'b1110;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("al_press", pp_al, (e == 5) ? 4'b0001 : 4'b0000);
            check("al_db", db_al, (e >= 5) ? 4'b0001 : 4'b0000);
        end
        btn_al = 4'b1111;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("al_release", rp_al, (e == 5) ? 4'b0001 : 4'b0000);
            check("al_long", lp_al, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 SHALL provide parameter CHANNELS, default 4, number of independent button channels (legal 1..32).
REQ-002 SHALL provide parameter DB_COUNT, default 120000, consecutive stable cycles required to accept a level change (legal >= 2; 10 ms at 12 MHz).
REQ-003 SHALL provide parameter ACTIVE_LOW, default 1, 1 = button pressed when input pin low.
REQ-004 SHALL provide parameter LONG_COUNT, default 12000000, pressed cycles before long-press event (legal >= 1; 1 s at 12 MHz).
REQ-005 SHALL provide port clk  input  1  single clock for all logic; every flop is rising-edge clk.
REQ-006 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL provide port btn_in  input  CHANNELS  raw asynchronous button pins.
REQ-008 SHALL provide port db_out  output  CHANNELS  debounced level, 1 = pressed (after ACTIVE_LOW polarity).
REQ-009 SHALL provide port press_pulse  output  CHANNELS  one-cycle pulse on accepted released->pressed change.
REQ-010 SHALL provide port release_pulse  output  CHANNELS  one-cycle pulse on accepted pressed->released change.
REQ-011 SHALL provide port long_pulse  output  CHANNELS  one-cycle pulse when press held LONG_COUNT cycles.

Function
REQ-012 Each channel SHALL be fully independent; simultaneous activity on any channels SHALL not interact.
REQ-013 Each channel SHALL pass btn_in through a two-flop synchronizer (s1, s2); polarity inversion for ACTIVE_LOW=1 SHALL be applied to s2 output to form lvl.
REQ-014 Debounce counter width SHALL be ceil(log2(DB_COUNT)) bits, unsigned, never wrapping.
REQ-015 On an edge where lvl != db_out and counter < DB_COUNT-1, counter SHALL increment.
REQ-016 On an edge where lvl != db_out and counter == DB_COUNT-1, db_out SHALL take lvl, counter SHALL clear, and press_pulse or release_pulse SHALL assert for that one cycle.
REQ-017 On any edge where lvl == db_out, counter SHALL clear; glitches shorter than DB_COUNT cycles SHALL produce no output change.
REQ-018 Latency: a clean level captured into s1 at edge 0 SHALL change db_out at edge DB_COUNT+1.
REQ-019 Pulse outputs SHALL be registered and SHALL never assert for two consecutive cycles on the same channel.
REQ-020 Long-press counter SHALL increment each cycle db_out == 1, saturate at LONG_COUNT, and clear on any cycle db_out == 0.
REQ-021 long_pulse SHALL assert exactly once per press, in the cycle the long-press counter reaches LONG_COUNT; releasing earlier SHALL produce none.
REQ-022 press_pulse and long_pulse SHALL never assert in the same cycle on one channel (guaranteed since LONG_COUNT >= 1).

Reset
REQ-023 While reset is high at a clk edge, s1, s2, db_out, all counters and all pulse outputs SHALL clear to 0.
REQ-024 Reset asserted mid-count or mid-press SHALL abort the operation with no pulse emitted; after release, a button still pressed SHALL yield press_pulse after the normal REQ-018 latency.
REQ-025 With ACTIVE_LOW=1 and idle-high pins, no press_pulse SHALL occur after reset.

Configuration
REQ-026 Macro MULTI_DEBOUNCE_LONGPRESS_EN defined: long-press counters and long_pulse logic SHALL be compiled per REQ-020..022.
REQ-027 Macro MULTI_DEBOUNCE_LONGPRESS_EN undefined: long-press counters SHALL not exist; long_pulse SHALL be tied constant 0; all other behaviour identical.

Verification (CHANNELS=4, DB_COUNT=4, LONG_COUNT=10, ACTIVE_LOW=0 unless stated)
REQ-028 btn_in[0] 0->1 sampled at edge 0, held -> db_out[0]=1 and press_pulse[0]=1 after edge 5, press_pulse[0]=0 after edge 6.
REQ-029 btn_in[1] high for 3 cycles then low -> db_out[1], press_pulse[1], release_pulse[1] stay 0 throughout.
REQ-030 btn_in[2] held high 20 cycles (macro defined) -> long_pulse[2]=1 for exactly one cycle, 10 cycles after press_pulse[2]; macro undefined -> long_pulse stays 0.
REQ-031 btn_in=4'b1111 at once, then 4'b0101 -> all four press_pulses in the same cycle; release_pulse[3] and release_pulse[1] in the same later cycle; channels 0,2 unaffected.
REQ-032 reset high 1 cycle at edge 3 of a press -> no pulse, counter restarts; db_out[0]=1 at edge 3+1+5.
REQ-033 ACTIVE_LOW=1, btn_in=4'b1111 through reset, then btn_in[0]=0 -> db_out=0 after reset, press_pulse[0] 5 edges after low sampled.
